// File: rtl/alsu_core.sv
// alsu_core -- registered 3-bit arithmetic / logic / shift unit.
//
// Stage 1 registers every control and data input. Stage 2 computes the
// selected operation from the stage-1 values and captures it into the
// 6-bit result register, so an input change reaches `out` two rising
// edges later.
//
// Parameters:
//   INPUT_PRIORITY  "A" | "B"   operand chosen when both bypass flags or
//                               both reduction flags are set
//   FULL_ADDER      "ON"|"OFF"  "ON" adds the registered carry-in
//
// Optional feature (compile-time macro ALSU_LED_WARN_EN):
//   defined   -> leds toggle 0000/FFFF every cycle an invalid command is held
//   undefined -> leds stay 0; out behaviour is identical
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset (clears all registers)
//   A, B       3-bit operands
//   opcode     3-bit operation select
//   cin        carry-in for addition
//   serial_in  bit shifted in by the shift operation
//   direction  shift/rotate direction, 1 = left, 0 = right
//   red_op_A   reduction on A for XOR/AND
//   red_op_B   reduction on B for XOR/AND
//   bypass_A   route A straight to out
//   bypass_B   route B straight to out
//   out        6-bit registered result
//   leds       16-bit invalid-command indicator
module alsu_core #(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  input  logic [2:0]  opcode,
  input  logic        cin,
  input  logic        serial_in,
  input  logic        direction,
  input  logic        red_op_A,
  input  logic        red_op_B,
  input  logic        bypass_A,
  input  logic        bypass_B,
  output logic [5:0]  out,
  output logic [15:0] leds
);

  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SHF = 3'b100;
  localparam logic [2:0] OP_ROT = 3'b101;

  logic [2:0]  a_d, a_q, b_d, b_q, opcode_d, opcode_q;
  logic        cin_d, cin_q, serial_in_d, serial_in_q, direction_d, direction_q;
  logic        red_a_d, red_a_q, red_b_d, red_b_q;
  logic        byp_a_d, byp_a_q, byp_b_d, byp_b_q;
  logic [5:0]  out_d, out_q;
  logic [15:0] leds_d, leds_q;
  logic        invalid;
  logic        red_use_a;
  logic [2:0]  red_opnd;
  logic [5:0]  op_res;

  function automatic logic [5:0] add_f(input logic [2:0] a, input logic [2:0] b,
                                       input logic c);
    return {3'b000, a} + {3'b000, b} + {5'b00000, c};
  endfunction

  function automatic logic [5:0] mul_f(input logic [2:0] a, input logic [2:0] b);
    return {3'b000, a} * {3'b000, b};
  endfunction

  // ---- stage 1: input capture ----
  always_comb begin
    a_d         = A;
    b_d         = B;
    opcode_d    = opcode;
    cin_d       = cin;
    serial_in_d = serial_in;
    direction_d = direction;
    red_a_d     = red_op_A;
    red_b_d     = red_op_B;
    byp_a_d     = bypass_A;
    byp_b_d     = bypass_B;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q         <= '0;
      b_q         <= '0;
      opcode_q    <= '0;
      cin_q       <= 1'b0;
      serial_in_q <= 1'b0;
      direction_q <= 1'b0;
      red_a_q     <= 1'b0;
      red_b_q     <= 1'b0;
      byp_a_q     <= 1'b0;
      byp_b_q     <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      opcode_q    <= opcode_d;
      cin_q       <= cin_d;
      serial_in_q <= serial_in_d;
      direction_q <= direction_d;
      red_a_q     <= red_a_d;
      red_b_q     <= red_b_d;
      byp_a_q     <= byp_a_d;
      byp_b_q     <= byp_b_d;
    end
  end

  // ---- stage 2: operation select and result capture ----
  always_comb begin
    invalid = (opcode_q[2:1] == 2'b11) ||
              ((red_a_q || red_b_q) && (opcode_q != OP_XOR) && (opcode_q != OP_AND));

    // Reduction operand: with both flags set the priority operand wins.
    red_use_a = (red_a_q && red_b_q) ? PRIO_A : red_a_q;
    red_opnd  = red_use_a ? a_q : b_q;

    op_res = '0;
    case (opcode_q)
      OP_ADD: op_res = add_f(a_q, b_q, FA_ON ? cin_q : 1'b0);
      OP_XOR: op_res = (red_a_q || red_b_q) ? {5'b00000, ^red_opnd} : {3'b000, a_q ^ b_q};
      OP_AND: op_res = (red_a_q || red_b_q) ? {5'b00000, &red_opnd} : {3'b000, a_q & b_q};
      OP_MUL: op_res = mul_f(a_q, b_q);
      OP_SHF: op_res = direction_q ? {out_q[4:0], serial_in_q} : {serial_in_q, out_q[5:1]};
      OP_ROT: op_res = direction_q ? {out_q[4:0], out_q[5]} : {out_q[0], out_q[5:1]};
      default: op_res = '0;
    endcase

    // Bypass overrides both the opcode result and the invalid clear.
    if (byp_a_q || byp_b_q) begin
      out_d = (byp_a_q && (!byp_b_q || PRIO_A)) ? {3'b000, a_q} : {3'b000, b_q};
    end else if (invalid) begin
      out_d = '0;
    end else begin
      out_d = op_res;
    end

`ifdef ALSU_LED_WARN_EN
    leds_d = invalid ? ~leds_q : 16'h0000;
`else
    leds_d = 16'h0000;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q  <= '0;
      leds_q <= '0;
    end else begin
      out_q  <= out_d;
      leds_q <= leds_d;
    end
  end

  assign out  = out_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_alsu_core.sv
// Testbench for alsu_core: directed literal checks from the test plan,
// followed by randomized stimulus compared every cycle against a
// behavioural model of the unit.
module tb_alsu_core;

  localparam string PRIO   = "A";
  localparam string FA     = "ON";
  localparam bit    PRIO_A = (PRIO == "A");
  localparam bit    FA_ON  = (FA == "ON");
`ifdef ALSU_LED_WARN_EN
  localparam int    BLINK  = 16'hFFFF;
`else
  localparam int    BLINK  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  out;
  logic [15:0] leds;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Model state: operands as seen one edge ago, and the expected outputs.
  int m_a, m_b, m_op, m_cin, m_sin, m_dir, m_ra, m_rb, m_ba, m_bb;
  int eo = 0;
  int el = 0;

  alsu_core #(.INPUT_PRIORITY(PRIO), .FULL_ADDER(FA)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out), .leds(leds)
  );

  always #5 clk = ~clk;

  // Behavioural model, advanced on each rising edge.
  always @(posedge clk) begin
    int r, x;
    bit inv;
    if (!rst) begin
      m_a = 0; m_b = 0; m_op = 0; m_cin = 0; m_sin = 0; m_dir = 0;
      m_ra = 0; m_rb = 0; m_ba = 0; m_bb = 0;
      eo = 0; el = 0;
    end else begin
      inv = (m_op >= 6) || ((m_ra || m_rb) && m_op != 1 && m_op != 2);
      x = (m_ra && m_rb) ? (PRIO_A ? m_a : m_b) : (m_ra ? m_a : m_b);
      case (m_op)
        0: r = m_a + m_b + (FA_ON ? m_cin : 0);
        1: r = (m_ra || m_rb) ? ($countones(x) % 2) : (m_a ^ m_b);
        2: r = (m_ra || m_rb) ? ((x == 7) ? 1 : 0) : (m_a & m_b);
        3: r = m_a * m_b;
        4: r = m_dir ? ((eo * 2 + m_sin) % 64) : (m_sin * 32 + eo / 2);
        5: r = m_dir ? ((eo * 2) % 64 + eo / 32) : ((eo % 2) * 32 + eo / 2);
        default: r = 0;
      endcase
      if (m_ba && m_bb) r = PRIO_A ? m_a : m_b;
      else if (m_ba)    r = m_a;
      else if (m_bb)    r = m_b;
      else if (inv)     r = 0;
`ifdef ALSU_LED_WARN_EN
      el = inv ? (el ^ 16'hFFFF) : 0;
`else
      el = 0;
`endif
      eo = r;
      m_a = A; m_b = B; m_op = opcode; m_cin = cin; m_sin = serial_in; m_dir = direction;
      m_ra = red_op_A; m_rb = red_op_B; m_ba = bypass_A; m_bb = bypass_B;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (out !== eo[5:0] || leds !== eo[5:0] * 0 + el[15:0]) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t out=%0d leds=%h required out=%0d leds=%h",
                 $time, out, leds, eo, el[15:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input int op, input int a, input int b, input int c,
                        input int sin, input int dir, input int ra, input int rb,
                        input int ba, input int bb);
    opcode = op[2:0]; A = a[2:0]; B = b[2:0]; cin = c[0]; serial_in = sin[0];
    direction = dir[0]; red_op_A = ra[0]; red_op_B = rb[0];
    bypass_A = ba[0]; bypass_B = bb[0];
  endtask

  task automatic rand_in();
    opcode    = 3'($urandom_range(0, 7));
    A         = 3'($urandom_range(0, 7));
    B         = 3'($urandom_range(0, 7));
    cin       = 1'($urandom_range(0, 1));
    serial_in = 1'($urandom_range(0, 1));
    direction = 1'($urandom_range(0, 1));
    red_op_A  = ($urandom_range(0, 5) == 0);
    red_op_B  = ($urandom_range(0, 5) == 0);
    bypass_A  = ($urandom_range(0, 7) == 0);
    bypass_B  = ($urandom_range(0, 7) == 0);
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic check_lit(input string name, input int exp_o, input int exp_l);
    n_tests++;
    if (out !== exp_o[5:0] || leds !== exp_l[15:0]) begin
      n_fail++;
      $display("FAIL %s: out=%0d leds=%h required out=%0d leds=%h",
               name, out, leds, exp_o, exp_l[15:0]);
    end
    n_tests++;
    if (eo != exp_o || el != exp_l) begin
      n_fail++;
      $display("FAIL %s_model: out=%0d leds=%h required out=%0d leds=%h",
               name, eo, el[15:0], exp_o, exp_l[15:0]);
    end
  endtask

  initial begin
    rst = 1'b0;
    rand_in();
    hold(2);
    check_lit("reset", 0, 0);
    chk_en = 1;

    rst = 1'b1;
    set_in(3, 5, 2, 0, 0, 0, 0, 0, 1, 0); hold(2); check_lit("bypass_a", 5, 0);
    set_in(3, 5, 2, 0, 0, 0, 0, 0, 1, 1); hold(2); check_lit("bypass_both", PRIO_A ? 5 : 2, 0);
    set_in(1, 6, 3, 0, 0, 0, 0, 0, 0, 0); hold(2); check_lit("xor", 5, 0);
    set_in(1, 6, 3, 0, 0, 0, 1, 0, 0, 0); hold(2); check_lit("xor_red_a", 0, 0);
    set_in(1, 6, 3, 0, 0, 0, 1, 1, 0, 0); hold(2); check_lit("xor_red_both", 0, 0);
    set_in(2, 7, 0, 0, 0, 0, 1, 0, 0, 0); hold(2); check_lit("and_red_a", 1, 0);
    set_in(0, 7, 7, 1, 0, 0, 0, 0, 0, 0); hold(2); check_lit("add_cin", FA_ON ? 15 : 14, 0);
    set_in(3, 7, 7, 0, 0, 0, 0, 0, 0, 0); hold(2); check_lit("mul", 49, 0);

    // Load out=1, then one cycle of shift-left (serial_in=1), then rotate right.
    set_in(3, 1, 0, 0, 0, 0, 0, 0, 1, 0); hold(2); check_lit("preload", 1, 0);
    set_in(4, 0, 0, 0, 1, 1, 0, 0, 0, 0); hold(1);
    set_in(5, 0, 0, 0, 0, 0, 0, 0, 0, 0); hold(1); check_lit("shift_left", 3, 0);
    hold(1); check_lit("rotate_right", 33, 0);

    // Invalid commands: out forced to 0, leds toggle while invalid persists.
    set_in(6, 3, 4, 0, 0, 0, 0, 0, 0, 0); hold(2); check_lit("inv_110", 0, BLINK);
    set_in(7, 3, 4, 0, 0, 0, 0, 0, 0, 0); hold(1); check_lit("inv_111_a", 0, 0);
    hold(1); check_lit("inv_111_b", 0, BLINK);
    set_in(4, 3, 4, 0, 1, 1, 0, 1, 0, 0); hold(1);
    hold(1); check_lit("inv_shift_red", 0, BLINK);
    set_in(1, 6, 3, 0, 0, 0, 0, 0, 0, 0); hold(2); check_lit("recover", 5, 0);

    // Randomized run, including occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 79) != 0);
      rand_in();
      hold(1);
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
